reorder_buffer_request_tagger: RTL and testbench

REORDER_BUFFER_REQUEST_TAGGER -- requirements
Module: reorder_buffer_request_tagger

---
 rtl/reorder_buffer_pkg.sv | 4 +
 rtl/skid_buffer.sv | 39 +++
 rtl/reorder_buffer_request_tagger.sv | 53 +++++
 tb/tb_reorder_buffer_request_tagger.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg: shared types for the reorder buffer request tagger
package reorder_buffer_pkg;
  typedef enum logic [1:0] {RUN, DRAIN, DRAINED} state_e;
endpackage

// File: rtl/skid_buffer.sv
// skid_buffer: 2-entry FIFO whose head is driven from registers and reads as zero while empty
module skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [1:0]   count_o,
  output logic [W-1:0] data_o
);
  logic [W-1:0] mem_q [2];
  logic         head_q, tail_q;
  logic [1:0]   count_q, count_d;
  logic         do_pop;
  assign valid_o = count_q != 2'd0;
  assign count_o = count_q;
  assign do_pop  = pop_i && valid_o;
  assign data_o  = valid_o ? mem_q[head_q] : '0;
  // The caller never pushes while full, so no overflow guard is needed here
  always_comb count_d = count_q + {1'b0, push_i} - {1'b0, do_pop};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q   <= '{default: '0};
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[tail_q] <= data_i;
        tail_q        <= ~tail_q;
      end
      if (do_pop) head_q <= ~head_q;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/reorder_buffer_request_tagger.sv
// reorder_buffer_request_tagger: tags each accepted request with the reorder buffer index
// reserved in the same cycle, buffers it in a 2-entry skid buffer, and supports draining.
module reorder_buffer_request_tagger
  import reorder_buffer_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 8,
  parameter int INDEX_WIDTH = $clog2(DEPTH)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   reserve_enable,
  input  logic [INDEX_WIDTH-1:0] reserve_index,
  input  logic                   reserve_full,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [INDEX_WIDTH-1:0] out_tag,
  input  logic                   drain_request,
  output logic                   drained
);
  state_e                        state_q, state_d;
  logic [1:0]                    count;
  logic                          accept;
  logic [WIDTH+INDEX_WIDTH-1:0]  head;
  // Readiness depends only on local state, never on out_ready
  assign in_ready       = !reset && state_q == RUN && !drain_request && !reserve_full && count != 2'd2;
  assign accept         = in_valid && in_ready;
  assign reserve_enable = accept;
  assign drained        = state_q == DRAINED;
  assign {out_data, out_tag} = head;
  always_comb
    state_d = (state_q == RUN && drain_request)      ? DRAIN   :
              (state_q == DRAIN && count == 2'd0)    ? DRAINED :
              (state_q == DRAINED && !drain_request) ? RUN     : state_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end
  skid_buffer #(.W(WIDTH + INDEX_WIDTH)) u_skid (
    .clk     (clock),
    .rst     (reset),
    .push_i  (accept),
    .pop_i   (out_ready),
    .data_i  ({in_data, reserve_index}),
    .valid_o (out_valid),
    .count_o (count),
    .data_o  (head)
  );
endmodule

// File: tb/tb_reorder_buffer_request_tagger.sv
// tb_reorder_buffer_request_tagger: directed checks of tagging, backpressure, drain and reset
module tb_reorder_buffer_request_tagger;
  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid, in_ready;
  logic [7:0] in_data;
  logic       reserve_enable;
  logic [1:0] reserve_index;
  logic       reserve_full;
  logic       out_valid, out_ready;
  logic [7:0] out_data;
  logic [1:0] out_tag;
  logic       drain_request, drained;
  int         checks = 0;
  int         errors = 0;
  int         pulses;

  reorder_buffer_request_tagger #(.WIDTH(8), .DEPTH(4)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .reserve_enable(reserve_enable), .reserve_index(reserve_index), .reserve_full(reserve_full),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .drain_request(drain_request), .drained(drained)
  );

  always #5 clock = ~clock;

  // Minimal controller model: hands out the next index after every reservation pulse
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      reserve_index <= 2'd0;
      pulses        <= 0;
    end else if (reserve_enable) begin
      reserve_index <= reserve_index + 2'd1;
      pulses        <= pulses + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b1; in_data = 8'h55; reserve_full = 1'b0;
    out_ready = 1'b0; drain_request = 1'b0;
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_reserve_enable", reserve_enable, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_drained", drained, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_tag", out_tag, 0);
    in_valid = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    // back-to-back traffic
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h11;
    #1;
    chk("b2b_in_ready", in_ready, 1);
    chk("b2b_reserve_enable", reserve_enable, 1);
    chk("b2b_no_early_valid", out_valid, 0);
    tick();
    chk("b2b_v0", out_valid, 1);
    chk("b2b_d0", out_data, 8'h11);
    chk("b2b_t0", out_tag, 0);
    in_data = 8'h22;
    tick();
    chk("b2b_d1", out_data, 8'h22);
    chk("b2b_t1", out_tag, 1);
    in_data = 8'h33;
    tick();
    chk("b2b_d2", out_data, 8'h33);
    chk("b2b_t2", out_tag, 2);
    in_valid = 1'b0;
    tick();
    chk("b2b_empty", out_valid, 0);
    // wrap-around: index continues 3 then 0
    in_valid = 1'b1; in_data = 8'h44;
    tick();
    chk("wrap_d3", out_data, 8'h44);
    chk("wrap_t3", out_tag, 3);
    in_data = 8'h45;
    tick();
    chk("wrap_d0", out_data, 8'h45);
    chk("wrap_t0", out_tag, 0);
    in_valid = 1'b0;
    tick();
    chk("wrap_empty", out_valid, 0);
    chk("wrap_pulses", pulses, 5);
    // full reorder buffer
    pulse_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'hB0 + 8'(i);
      tick();
      chk("full_data", out_data, 8'hB0 + i);
      chk("full_tag", out_tag, i);
    end
    reserve_full = 1'b1; in_data = 8'hB4;
    #1;
    chk("full_in_ready", in_ready, 0);
    chk("full_reserve_enable", reserve_enable, 0);
    tick();
    chk("full_no_out", out_valid, 0);
    chk("full_in_ready_held", in_ready, 0);
    reserve_full = 1'b0;
    #1;
    chk("full_released", in_ready, 1);
    tick();
    chk("full_5th_valid", out_valid, 1);
    chk("full_5th_data", out_data, 8'hB4);
    chk("full_5th_tag", out_tag, 0);
    in_valid = 1'b0;
    // backpressure
    pulse_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hA0;
    tick();
    in_data = 8'hA1;
    #1;
    chk("bp_ready_one", in_ready, 1);
    tick();
    in_data = 8'hA2;
    #1;
    chk("bp_ready_two", in_ready, 0);
    tick();
    chk("bp_hold_data", out_data, 8'hA0);
    chk("bp_hold_tag", out_tag, 0);
    chk("bp_hold_ready", in_ready, 0);
    out_ready = 1'b1;
    #1;
    chk("bp_no_comb_path", in_ready, 0);
    tick();
    chk("bp_d1", out_data, 8'hA1);
    chk("bp_t1", out_tag, 1);
    chk("bp_ready_again", in_ready, 1);
    tick();
    chk("bp_d2", out_data, 8'hA2);
    chk("bp_t2", out_tag, 2);
    in_valid = 1'b0;
    tick();
    chk("bp_empty", out_valid, 0);
    // drain with two buffered entries
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hC0;
    tick();
    in_data = 8'hC1;
    tick();
    in_data = 8'hC2; drain_request = 1'b1;
    #1;
    chk("drain_in_ready", in_ready, 0);
    chk("drain_no_reserve", reserve_enable, 0);
    tick();
    chk("drain_not_yet", drained, 0);
    chk("drain_head_tag", out_tag, 3);
    out_ready = 1'b1;
    tick();
    chk("drain_d1", out_data, 8'hC1);
    chk("drain_t1", out_tag, 0);
    tick();
    chk("drain_last_pop", out_valid, 0);
    chk("drain_pending", drained, 0);
    tick();
    chk("drain_done", drained, 1);
    chk("drain_done_ready", in_ready, 0);
    drain_request = 1'b0;
    #1;
    chk("drained_ready_low", in_ready, 0);
    tick();
    chk("run_again", in_ready, 1);
    chk("run_not_drained", drained, 0);
    in_valid = 1'b0;
    tick();
    tick();
    // drain with an empty buffer
    drain_request = 1'b1;
    tick();
    chk("edrain_state1", drained, 0);
    tick();
    chk("edrain_state2", drained, 1);
    drain_request = 1'b0;
    tick();
    chk("edrain_run", drained, 0);
    // reset with one buffered entry
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hD0;
    tick();
    in_valid = 1'b0;
    chk("mid_buffered", out_valid, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_ready", in_ready, 0);
    #1;
    reset = 1'b0;
    tick();
    in_valid = 1'b1; in_data = 8'hD1; out_ready = 1'b1;
    #1;
    chk("post_rst_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_data", out_data, 8'hD1);
    chk("post_rst_tag", out_tag, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
